timer_regfile: RTL and testbench

Bus-mapped control/status register block that sits directly upstream of the `timing` counter. It converts single-word bus reads and writes into the `ro_*` control inputs of the timer, and captures the timer's `rf_*` outputs for software readback. It also turns the timer's interrupt output into a sticky, maskable `irq` line.

---
 rtl/timer_regfile.sv | 140 ++++++++++++++
 tb/tb_timer_regfile.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_regfile.sv
// Bus-mapped control/status registers for the timing counter: drives the timer's
// ro_* controls, returns its rf_* state, and turns its interrupt into a sticky, maskable irq.
module timer_regfile #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_sel,
  input  logic              bus_wr,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ack,
  output logic              ro_trig_start,
  output logic              ro_trig_halt,
  output logic              ro_mode,
  output logic [31:0]       ro_termcount,
  input  logic              rf_status,
  input  logic [31:0]       rf_currcount,
  input  logic              rf_int,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] AddrCtrl      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrTermcount = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrStatus    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrCurrcount = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] AddrIntstat   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AddrInten     = ADDR_W'(5);

  typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

  state_e      state_q;
  logic        pend_q;
  logic        werr_q;
  logic        int_en_q;
  logic        rf_int_q;

  logic        access;
  logic        wr_en;
  logic        ctrl_wr;
  logic        tc_wr;
  logic        intstat_wr;
  logic        inten_wr;
  logic        werr_set;
  logic        int_rise;
  logic [31:0] rd_data;

  assign access   = (state_q == StIdle) && bus_sel;
  assign wr_en    = access && bus_wr;
  assign int_rise = rf_int && !rf_int_q;

  always_comb begin
    rd_data    = '0;
    ctrl_wr    = 1'b0;
    tc_wr      = 1'b0;
    intstat_wr = 1'b0;
    inten_wr   = 1'b0;
    case (bus_addr)
      AddrCtrl: begin
        rd_data[2] = ro_mode;
        ctrl_wr    = wr_en;
      end
      AddrTermcount: begin
        rd_data = ro_termcount;
        tc_wr   = wr_en;
      end
      AddrStatus: begin
        rd_data[0] = rf_status;
        rd_data[1] = werr_q;
      end
      AddrCurrcount: rd_data = rf_currcount;
      AddrIntstat: begin
        rd_data[0] = pend_q;
        rd_data[1] = werr_q;
        intstat_wr = wr_en;
      end
      AddrInten: begin
        rd_data[0] = int_en_q;
        inten_wr   = wr_en;
      end
      default: rd_data = '0;
    endcase
  end

  // A CTRL write only counts as a MODE write if it tries to change MODE, so that
  // START/HALT on a running timer do not raise WERR. Any TERMCOUNT write counts.
  assign werr_set = rf_status &&
                    ((ctrl_wr && (bus_wdata[2] != ro_mode)) || tc_wr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      bus_ack       <= 1'b0;
      bus_rdata     <= '0;
      ro_trig_start <= 1'b0;
      ro_trig_halt  <= 1'b0;
      ro_mode       <= 1'b0;
      ro_termcount  <= '0;
      pend_q        <= 1'b0;
      werr_q        <= 1'b0;
      int_en_q      <= 1'b0;
      rf_int_q      <= 1'b0;
    end else begin
      rf_int_q      <= rf_int;
      bus_ack       <= 1'b0;
      bus_rdata     <= '0;
      ro_trig_start <= 1'b0;
      ro_trig_halt  <= 1'b0;

      // Set beats clear when both land on the same edge.
      pend_q <= int_rise || (pend_q && !(intstat_wr && bus_wdata[0]));
      werr_q <= werr_set || (werr_q && !(intstat_wr && bus_wdata[1]));

      if (inten_wr) int_en_q <= bus_wdata[0];
      if (ctrl_wr && !rf_status) ro_mode <= bus_wdata[2];
      if (tc_wr && !rf_status) ro_termcount <= bus_wdata;

      case (state_q)
        StIdle: begin
          if (access) begin
            state_q <= StAck;
            bus_ack <= 1'b1;
            if (!bus_wr) bus_rdata <= rd_data;
            if (ctrl_wr) begin
              ro_trig_halt  <= bus_wdata[1];
              ro_trig_start <= bus_wdata[0] && !bus_wdata[1];
            end
          end
        end
        StAck:   state_q <= StWait;
        StWait:  if (!bus_sel) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign irq = pend_q && int_en_q;

endmodule

// File: tb/tb_timer_regfile.sv
// Self-checking bench for timer_regfile: directed test-plan steps followed by
// random bus traffic, all checked against a register-level reference model.
module tb_timer_regfile;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          bus_sel;
  logic          bus_wr;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic          bus_ack;
  logic          ro_trig_start;
  logic          ro_trig_halt;
  logic          ro_mode;
  logic [31:0]   ro_termcount;
  logic          rf_status;
  logic [31:0]   rf_currcount;
  logic          rf_int;
  logic          irq;

  timer_regfile #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus_sel      (bus_sel),
    .bus_wr       (bus_wr),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .ro_trig_start(ro_trig_start),
    .ro_trig_halt (ro_trig_halt),
    .ro_mode      (ro_mode),
    .ro_termcount (ro_termcount),
    .rf_status    (rf_status),
    .rf_currcount (rf_currcount),
    .rf_int       (rf_int),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural register contents.
  logic        m_mode;
  logic [31:0] m_tc;
  logic        m_pend;
  logic        m_werr;
  logic        m_inten;
  logic        m_prev_int;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 1'b0; m_tc = '0; m_pend = 1'b0; m_werr = 1'b0; m_inten = 1'b0; m_prev_int = 1'b0;
  endtask

  // One complete access, starting and ending on a falling edge with the DUT idle.
  task automatic bus_access(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                            input logic st, input logic [31:0] cc, input logic iv,
                            input string tag, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_start, exp_halt, rise, clr_p, clr_w, wset;
    int          cycles;
    exp_rd = '0; exp_start = 1'b0; exp_halt = 1'b0; clr_p = 1'b0; clr_w = 1'b0; wset = 1'b0;
    if (!wr) begin
      case (int'(a))
        0: exp_rd = {29'd0, m_mode, 2'b00};
        1: exp_rd = m_tc;
        2: exp_rd = {30'd0, m_werr, st};
        3: exp_rd = cc;
        4: exp_rd = {30'd0, m_werr, m_pend};
        5: exp_rd = {31'd0, m_inten};
        default: exp_rd = '0;
      endcase
    end else begin
      case (int'(a))
        0: begin
          exp_halt  = wd[1];
          exp_start = wd[0] & ~wd[1];
          if (st) wset = (wd[2] != m_mode);
          else m_mode = wd[2];
        end
        1: if (st) wset = 1'b1; else m_tc = wd;
        4: begin clr_p = wd[0]; clr_w = wd[1]; end
        5: m_inten = wd[0];
        default: ;
      endcase
    end
    rise       = iv & ~m_prev_int;
    m_prev_int = iv;
    m_pend     = rise | (m_pend & ~clr_p);
    m_werr     = wset | (m_werr & ~clr_w);

    bus_sel = 1'b1; bus_wr = wr; bus_addr = a; bus_wdata = wd;
    rf_status = st; rf_currcount = cc; rf_int = iv;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus_ack && cycles < 8);
    check({tag, "/ack_latency"}, 32'(cycles), 32'd1);
    rd = bus_rdata;
    if (!wr) check({tag, "/rdata"}, bus_rdata, exp_rd);
    check({tag, "/start"}, {31'd0, ro_trig_start}, {31'd0, exp_start});
    check({tag, "/halt"}, {31'd0, ro_trig_halt}, {31'd0, exp_halt});
    check({tag, "/mode"}, {31'd0, ro_mode}, {31'd0, m_mode});
    check({tag, "/termcount"}, ro_termcount, m_tc);
    check({tag, "/irq"}, {31'd0, irq}, {31'd0, m_pend & m_inten});
    bus_sel = 1'b0;
    @(negedge clk);
    check({tag, "/ack_width"}, {31'd0, bus_ack}, 32'd0);
    check({tag, "/pulse_width"}, {30'd0, ro_trig_start, ro_trig_halt}, 32'd0);
    check({tag, "/rdata_idle"}, bus_rdata, 32'd0);
    @(negedge clk);
  endtask

  task automatic drive_int(input logic v);
    rf_int = v;
    @(negedge clk);
    if (v && !m_prev_int) m_pend = 1'b1;
    m_prev_int = v;
  endtask

  initial begin
    logic [31:0] rd;
    int          acks;

    reset = 1'b1; bus_sel = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
    rf_status = 1'b0; rf_currcount = '0; rf_int = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset/irq", {31'd0, irq}, 32'd0);
    check("reset/ro", {30'd0, ro_trig_start, ro_trig_halt}, 32'd0);
    check("reset/mode", {31'd0, ro_mode}, 32'd0);
    check("reset/termcount", ro_termcount, 32'd0);
    check("reset/ack", {31'd0, bus_ack}, 32'd0);
    check("reset/rdata", bus_rdata, 32'd0);

    for (int i = 0; i < 6; i++) begin
      bus_access(1'b0, AW'(i), '0, 1'b0, '0, 1'b0, "reset_read", rd);
      check("reset_read/zero", rd, 32'd0);
    end

    bus_access(1'b1, AW'(1), 32'h0000_0010, 1'b0, '0, 1'b0, "wr_tc", rd);
    bus_access(1'b1, AW'(0), 32'h0000_0005, 1'b0, '0, 1'b0, "wr_ctrl5", rd);
    check("wr_ctrl5/tc_value", ro_termcount, 32'h10);
    check("wr_ctrl5/mode_value", {31'd0, ro_mode}, 32'd1);
    bus_access(1'b1, AW'(0), 32'h0000_0003, 1'b0, '0, 1'b0, "wr_ctrl3", rd);

    bus_access(1'b1, AW'(1), 32'hFFFF_FFFF, 1'b1, '0, 1'b0, "wp_tc", rd);
    check("wp_tc/held", ro_termcount, 32'h10);
    bus_access(1'b0, AW'(2), '0, 1'b1, '0, 1'b0, "status_werr", rd);
    check("status_werr/value", rd, 32'h3);
    bus_access(1'b1, AW'(4), 32'h2, 1'b1, '0, 1'b0, "w1c_werr", rd);
    bus_access(1'b0, AW'(2), '0, 1'b1, '0, 1'b0, "status_clr", rd);
    check("status_clr/value", rd, 32'h1);

    bus_access(1'b1, AW'(5), 32'h1, 1'b0, '0, 1'b0, "inten", rd);
    drive_int(1'b1);
    check("int_rise/irq", {31'd0, irq}, 32'd1);
    bus_access(1'b1, AW'(4), 32'h1, 1'b0, '0, 1'b1, "w1c_pend", rd);
    check("w1c_pend/irq", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge clk);
    check("int_held/irq", {31'd0, irq}, 32'd0);
    drive_int(1'b0);
    bus_access(1'b1, AW'(4), 32'h1, 1'b0, '0, 1'b1, "set_wins", rd);
    check("set_wins/irq", {31'd0, irq}, 32'd1);

    // Held bus_sel: a single acknowledge only.
    bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = AW'(5);
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_ack) acks++;
    end
    check("held_sel/acks", 32'(acks), 32'd1);
    bus_sel = 1'b0;
    repeat (2) @(negedge clk);

    // Reset arriving while the ack and start pulse are up.
    bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = AW'(0); bus_wdata = 32'h1;
    @(negedge clk);
    check("rst_ack/ack_up", {31'd0, bus_ack}, 32'd1);
    check("rst_ack/start_up", {31'd0, ro_trig_start}, 32'd1);
    reset = 1'b1; bus_sel = 1'b0; rf_int = 1'b0;
    @(negedge clk);
    check("rst_ack/ack", {31'd0, bus_ack}, 32'd0);
    check("rst_ack/start", {31'd0, ro_trig_start}, 32'd0);
    check("rst_ack/irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    bus_access(1'b0, AW'(5), '0, 1'b0, '0, 1'b0, "post_rst", rd);

    for (int i = 0; i < 300; i++) begin
      logic          wr;
      logic [AW-1:0] a;
      logic [31:0]   wd;
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(6, 15)) : AW'($urandom_range(0, 5));
      wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
      bus_access(wr, a, wd, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 "random", rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
